// File: rtl/force_ring_drain_ctrl.sv
// ============================================================================
// Module   : force_ring_drain_ctrl
// Purpose  : Tracks one force iteration from start to ring quiescence and
//            pulses o_ring_drained. Optional packet counters: FRC_RING_PKT_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module force_ring_drain_ctrl #(
  parameter int NUM_NODES     = 8,
  parameter int QUIET_CYCLES  = 16,
  parameter int TIMEOUT_WIDTH = 20,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [NUM_NODES-1:0] i_pe_done,
  input  logic [NUM_NODES-1:0] i_buffer_empty,
  input  logic [NUM_NODES-1:0] i_ring_valid,
  input  logic [NUM_NODES-1:0] i_inject_valid,
  input  logic [NUM_NODES-1:0] i_deliver_valid,
  output logic                 o_busy,
  output logic                 o_ring_drained,
  output logic                 o_timeout,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_inject_cnt,
  output logic [CNT_WIDTH-1:0] o_deliver_cnt,
  output logic                 o_err_mismatch
);

  localparam int             QW         = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0]  QUIET_LAST = QW'(QUIET_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state, state_nx;
  logic [NUM_NODES-1:0]     done_latch, done_latch_nx;
  logic [QW-1:0]            quiet_cnt, quiet_cnt_nx;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt, wd_cnt_nx;
  logic                     timeout_nx;
  logic                     quiet;

  assign quiet = (&i_buffer_empty) & ~(|i_ring_valid) & ~(|i_inject_valid) & ~(|i_deliver_valid);

  always_comb begin
    state_nx      = state;
    done_latch_nx = done_latch | i_pe_done;
    quiet_cnt_nx  = quiet_cnt;
    wd_cnt_nx     = wd_cnt;
    timeout_nx    = o_timeout;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          // pe_done seen before the accepted start belongs to a previous iteration
          done_latch_nx = '0;
          timeout_nx    = 1'b0;
          state_nx      = S_RUN;
        end
      end
      S_RUN: begin
        quiet_cnt_nx = '0;
        wd_cnt_nx    = '0;
        if (&done_latch_nx) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        wd_cnt_nx    = wd_cnt + TIMEOUT_WIDTH'(1);
        quiet_cnt_nx = quiet ? quiet_cnt + QW'(1) : '0;
        if (quiet && (quiet_cnt == QUIET_LAST)) begin
          state_nx = S_DONE;
        end else if (&wd_cnt_nx) begin
          timeout_nx = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      done_latch     <= '0;
      quiet_cnt      <= '0;
      wd_cnt         <= '0;
      o_busy         <= 1'b0;
      o_ring_drained <= 1'b0;
      o_timeout      <= 1'b0;
    end else begin
      state          <= state_nx;
      done_latch     <= done_latch_nx;
      quiet_cnt      <= quiet_cnt_nx;
      wd_cnt         <= wd_cnt_nx;
      o_busy         <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
      o_ring_drained <= (state_nx == S_DONE);
      o_timeout      <= timeout_nx;
    end
  end

  assign o_state = state;

`ifdef FRC_RING_PKT_CNT_EN
  localparam int PW = $clog2(NUM_NODES + 1);

  function automatic logic [PW-1:0] popcnt(input logic [NUM_NODES-1:0] v);
    popcnt = '0;
    for (int n = 0; n < NUM_NODES; n++) popcnt = popcnt + PW'(v[n]);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [PW-1:0] b);
    logic [CNT_WIDTH:0] s;
    s       = {1'b0, a} + (CNT_WIDTH+1)'(b);
    sat_add = s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  logic                 start_acc;
  logic                 counting;
  logic [CNT_WIDTH-1:0] inj_nx, del_nx;

  assign start_acc = (state == S_IDLE) && i_start;
  assign counting  = (state == S_RUN) || (state == S_DRAIN);
  assign inj_nx    = start_acc ? '0 : (counting ? sat_add(o_inject_cnt, popcnt(i_inject_valid)) : o_inject_cnt);
  assign del_nx    = start_acc ? '0 : (counting ? sat_add(o_deliver_cnt, popcnt(i_deliver_valid)) : o_deliver_cnt);

  // Mismatch is judged on the counts that become visible in the DONE cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      o_inject_cnt   <= '0;
      o_deliver_cnt  <= '0;
      o_err_mismatch <= 1'b0;
    end else begin
      o_inject_cnt  <= inj_nx;
      o_deliver_cnt <= del_nx;
      if (start_acc)                                    o_err_mismatch <= 1'b0;
      else if ((state_nx == S_DONE) && (inj_nx != del_nx)) o_err_mismatch <= 1'b1;
    end
  end
`else
  assign o_inject_cnt   = '0;
  assign o_deliver_cnt  = '0;
  assign o_err_mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_force_ring_drain_ctrl.sv
// Scoreboard bench for force_ring_drain_ctrl: expected drain/timeout events are
// queued when an iteration is started and compared when the DUT signals completion.
`default_nettype none
`timescale 1ns/1ps

module tb_force_ring_drain_ctrl;
  localparam int NN = 8;
  localparam int QC = 16;
  localparam int TW = 6;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic [NN-1:0] i_pe_done = '0;
  logic [NN-1:0] i_buffer_empty = '1;
  logic [NN-1:0] i_ring_valid = '0;
  logic [NN-1:0] i_inject_valid = '0;
  logic [NN-1:0] i_deliver_valid = '0;
  logic          o_busy, o_ring_drained, o_timeout, o_err_mismatch;
  logic [1:0]    o_state;
  logic [CW-1:0] o_inject_cnt, o_deliver_cnt;

  force_ring_drain_ctrl #(
    .NUM_NODES(NN), .QUIET_CYCLES(QC), .TIMEOUT_WIDTH(TW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_pe_done(i_pe_done),
    .i_buffer_empty(i_buffer_empty), .i_ring_valid(i_ring_valid),
    .i_inject_valid(i_inject_valid), .i_deliver_valid(i_deliver_valid),
    .o_busy(o_busy), .o_ring_drained(o_ring_drained), .o_timeout(o_timeout),
    .o_state(o_state), .o_inject_cnt(o_inject_cnt), .o_deliver_cnt(o_deliver_cnt),
    .o_err_mismatch(o_err_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit to;
    int inj;
    int del;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until a drained pulse or timeout appears; seen stays -1 if the budget runs out
  task automatic wait_evt(input int budget, output int seen, output bit gd, output bit gt);
    seen = -1; gd = 1'b0; gt = 1'b0;
    for (int i = 0; i < budget && seen < 0; i++) begin
      tick();
      if (o_ring_drained || o_timeout) begin
        seen = cyc; gd = o_ring_drained; gt = o_timeout;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++; if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", o_busy); end
    n_checks++; if (o_ring_drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained: got %0b expected 0", o_ring_drained); end
    n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b expected 0", o_timeout); end
    n_checks++; if (o_inject_cnt !== '0 || o_deliver_cnt !== '0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", o_inject_cnt, o_deliver_cnt); end
    n_checks++; if (o_err_mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b expected 0", o_err_mismatch); end
    rst = 1'b0;
    tick();
    n_checks++; if (o_state !== 2'd0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: state=%0d busy=%0b expected 0/0", o_state, o_busy); end
  endtask

  task automatic test_nominal();
    int c0, seen; bit gd, gt; exp_t e;
    c0 = cyc;
    i_start = 1'b1;
    sb.push_back('{c0 + 20, 1'b0, 0, 0});
    tick(); i_start = 1'b0;
    n_checks++; if (o_state !== 2'd1 || o_busy !== 1'b1) begin n_fail++; $display("FAIL nominal_run: state=%0d busy=%0b expected 1/1", o_state, o_busy); end
    tick(); tick();
    i_pe_done = '1;
    tick(); i_pe_done = '0;
    n_checks++; if (o_state !== 2'd2 || cyc != c0 + 4) begin n_fail++; $display("FAIL nominal_drain: state=%0d at rel cycle %0d expected 2 at 4", o_state, cyc - c0); end
    wait_evt(60, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || !gd || gt) begin n_fail++; $display("FAIL nominal_pulse: cycle=%0d drained=%0b timeout=%0b expected cycle=%0d 1/0", seen, gd, gt, e.cyc); end
    n_checks++; if (o_state !== 2'd3 || o_busy !== 1'b0) begin n_fail++; $display("FAIL nominal_done: state=%0d busy=%0b expected 3/0", o_state, o_busy); end
    tick();
    n_checks++; if (o_state !== 2'd0 || o_ring_drained !== 1'b0) begin n_fail++; $display("FAIL nominal_idle: state=%0d drained=%0b expected 0/0", o_state, o_ring_drained); end
  endtask

  task automatic test_blip();
    int c0, seen; bit gd, gt; exp_t e;
    c0 = cyc;
    i_start = 1'b1;
    tick(); i_start = 1'b0; i_pe_done = '1;
    tick(); i_pe_done = '0;
    repeat (10) tick();
    // quiet_cnt is 10 here; the blip restarts the count so 16 quiet cycles follow it
    i_ring_valid = 8'h08;
    sb.push_back('{cyc + QC + 1, 1'b0, 0, 0});
    tick(); i_ring_valid = '0;
    wait_evt(60, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || !gd || gt) begin n_fail++; $display("FAIL blip_pulse: rel cycle=%0d drained=%0b expected rel cycle=%0d", seen - c0, gd, e.cyc - c0); end
    tick();
  endtask

  task automatic test_stagger();
    int c0, seen, pulses; bit gd, gt; exp_t e;
    i_pe_done = '1;
    tick(); i_pe_done = '0;
    c0 = cyc;
    i_start = 1'b1;
    sb.push_back('{c0 + 25, 1'b0, 0, 0});
    tick(); i_start = 1'b0;
    for (int i = 0; i < NN; i++) begin
      i_pe_done = NN'(1) << i;
      tick();
      if (i == NN - 2) begin
        n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL stagger_run: state=%0d expected 1", o_state); end
      end
    end
    i_pe_done = '0;
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL stagger_drain: state=%0d expected 2", o_state); end
    wait_evt(60, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || !gd || gt) begin n_fail++; $display("FAIL stagger_pulse: rel cycle=%0d drained=%0b expected rel cycle=%0d", seen - c0, gd, e.cyc - c0); end
    pulses = 0;
    repeat (20) begin tick(); if (o_ring_drained) pulses++; end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL stagger_once: extra pulses=%0d expected 0", pulses); end
  endtask

  task automatic test_start_ignored();
    int c0, seen; bit gd, gt; exp_t e;
    c0 = cyc;
    i_start = 1'b1;
    sb.push_back('{c0 + 20, 1'b0, 0, 0});
    tick(); i_start = 1'b0; i_pe_done = 8'h0F;
    tick(); i_pe_done = '0; i_start = 1'b1;
    tick(); i_start = 1'b0;
    n_checks++; if (o_state !== 2'd1) begin n_fail++; $display("FAIL busy_start_run: state=%0d expected 1", o_state); end
    i_pe_done = 8'hF0;
    tick(); i_pe_done = '0;
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL busy_start_latch: state=%0d expected 2", o_state); end
    tick(); tick();
    i_start = 1'b1;
    tick(); i_start = 1'b0;
    n_checks++; if (o_state !== 2'd2) begin n_fail++; $display("FAIL drain_start: state=%0d expected 2", o_state); end
    wait_evt(60, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || !gd) begin n_fail++; $display("FAIL busy_start_pulse: rel cycle=%0d expected %0d", seen - c0, e.cyc - c0); end
    i_start = 1'b1;
    tick(); i_start = 1'b0;
    n_checks++; if (o_state !== 2'd0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL done_start: state=%0d busy=%0b expected 0/0", o_state, o_busy); end
    tick();
  endtask

  task automatic test_timeout();
    int c0, seen; bit gd, gt; exp_t e;
    i_buffer_empty = 8'hFB;
    c0 = cyc;
    i_start = 1'b1;
    sb.push_back('{c0 + 65, 1'b1, 0, 0});
    tick(); i_start = 1'b0; i_pe_done = '1;
    tick(); i_pe_done = '0;
    wait_evt(150, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || gd || !gt) begin n_fail++; $display("FAIL timeout_evt: rel cycle=%0d drained=%0b timeout=%0b expected rel %0d 0/1", seen - c0, gd, gt, e.cyc - c0); end
    n_checks++; if (o_state !== 2'd0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: state=%0d busy=%0b expected 0/0", o_state, o_busy); end
    i_buffer_empty = '1;
    tick();
    n_checks++; if (o_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0b expected 1", o_timeout); end
    c0 = cyc;
    i_start = 1'b1;
    sb.push_back('{c0 + 18, 1'b0, 0, 0});
    tick(); i_start = 1'b0; i_pe_done = '1;
    n_checks++; if (o_timeout !== 1'b0 || o_state !== 2'd1) begin n_fail++; $display("FAIL timeout_clear: timeout=%0b state=%0d expected 0/1", o_timeout, o_state); end
    tick(); i_pe_done = '0;
    wait_evt(60, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || !gd || gt) begin n_fail++; $display("FAIL timeout_rerun: rel cycle=%0d drained=%0b expected rel %0d", seen - c0, gd, e.cyc - c0); end
    tick();
  endtask

  task automatic test_rst_drain();
    int seen; bit gd, gt;
    i_start = 1'b1;
    tick(); i_start = 1'b0; i_pe_done = '1;
    tick(); i_pe_done = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick(); rst = 1'b0;
    n_checks++; if (o_state !== 2'd0 || o_busy !== 1'b0 || o_ring_drained !== 1'b0 || o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_drain: state=%0d busy=%0b drained=%0b timeout=%0b expected all 0", o_state, o_busy, o_ring_drained, o_timeout);
    end
    wait_evt(30, seen, gd, gt);
    n_checks++; if (gd || gt) begin n_fail++; $display("FAIL rst_drain_quiet: drained=%0b timeout=%0b expected 0/0", gd, gt); end
  endtask

`ifdef FRC_RING_PKT_CNT_EN
  task automatic test_pkt_count(input logic [NN-1:0] last_del, input int exp_del, input bit exp_err);
    int c0, seen; bit gd, gt; exp_t e;
    c0 = cyc;
    i_start = 1'b1;
    sb.push_back('{c0 + 23, 1'b0, 37, exp_del});
    tick(); i_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      i_inject_valid  = (i < 4) ? {NN{1'b1}} : 8'h1F;
      i_deliver_valid = (i < 4) ? {NN{1'b1}} : last_del;
      tick();
    end
    i_inject_valid = '0; i_deliver_valid = '0; i_pe_done = '1;
    tick(); i_pe_done = '0;
    wait_evt(60, seen, gd, gt);
    e = sb.pop_front();
    n_checks++; if (seen != e.cyc || !gd) begin n_fail++; $display("FAIL pkt_pulse: rel cycle=%0d expected %0d", seen - c0, e.cyc - c0); end
    n_checks++; if (o_inject_cnt !== CW'(e.inj) || o_deliver_cnt !== CW'(e.del)) begin
      n_fail++; $display("FAIL pkt_counts: got %0d/%0d expected %0d/%0d", o_inject_cnt, o_deliver_cnt, e.inj, e.del);
    end
    tick();
    n_checks++; if (o_err_mismatch !== exp_err) begin n_fail++; $display("FAIL pkt_err: got %0b expected %0b", o_err_mismatch, exp_err); end
    n_checks++; if (o_inject_cnt !== CW'(e.inj) || o_deliver_cnt !== CW'(e.del)) begin
      n_fail++; $display("FAIL pkt_hold: got %0d/%0d expected %0d/%0d", o_inject_cnt, o_deliver_cnt, e.inj, e.del);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_blip();
    test_stagger();
    test_start_ignored();
    test_timeout();
    test_rst_drain();
`ifdef FRC_RING_PKT_CNT_EN
    test_pkt_count(8'h1F, 37, 1'b0);
    test_pkt_count(8'h0F, 36, 1'b1);
`endif
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: %0d entries left expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
